probe_capture: RTL and testbench
================================

// Module: probe_capture
// PURPOSE
//  In-fabric logic-analyser core. Samples a parametrised probe bus every clk into a
//  circular buffer and stops after a masked trigger with a fixed pre/post split.
//  Readout is by a pull handshake that delivers samples oldest-first.
//  Sits beside uart_rx / pwm logic and replaces vendor JTAG debug cores.
//  The buffer is drained over the existing UART path.
// PARAMETERS
//  PROBE_W   24   probe bus width, 1..64
//  DEPTH     256  samples in buffer; power of 2, >=4
//  PRE_TRIG  32   samples kept before trigger sample; 0..DEPTH-1
// PORTS
//  clk          in   1        system clock; sole clock domain
//  rst_n        in   1        asynchronous active-low reset
//  probe_i      in   PROBE_W  signals under observation, synchronous to clk
//  arm_i        in   1        1-cycle pulse: start a capture
//  abort_i      in   1        1-cycle pulse: return to IDLE, discard capture
//  trig_mode_i  in   1        0 = masked match, 1 = masked change vs previous sample
//  trig_mask_i  in   PROBE_W  1 = bit takes part in trigger
//  trig_val_i   in   PROBE_W  compare value for mode 0
//  rd_req_i     in   1        pull one sample; honoured only in DONE
//  rd_data_o    out  PROBE_W  sample; valid only with rd_valid_o
//  rd_valid_o   out  1        1-cycle strobe, 1 clk after an accepted rd_req_i
//  rd_last_o    out  1        qualifies rd_valid_o for the final (DEPTH-th) sample
//  armed_o      out  1        high in PRE and WAIT
//  triggered_o  out  1        high in POST and DONE
//  done_o       out  1        high in DONE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pointers and counters 0; buffer contents undefined.
//  FSM: IDLE -arm-> PRE -(PRE_TRIG samples written)-> WAIT -trig-> POST
//   -(DEPTH-PRE_TRIG-1 samples after trigger)-> DONE.
//   PRE_TRIG=0: the cycle after arm enters WAIT directly.
//   abort_i, from any state: IDLE next cycle; abort_i wins over a simultaneous arm_i.
//   arm_i in PRE/WAIT/POST: ignored. arm_i in IDLE/DONE: restart.
//  Writes: in PRE, WAIT and POST, probe_i is written at wr_ptr each clk;
//   wr_ptr wraps modulo DEPTH.
//  Trigger is evaluated on the sample written in the same cycle. It is qualified only
//   in WAIT, so a trigger during PRE is lost and guarantees PRE_TRIG true pre-samples.
//   Mode 0: ((probe_i ^ trig_val_i) & trig_mask_i) == 0.
//   Mode 1: ((probe_i ^ prev) & trig_mask_i) != 0. prev is the registered previous
//   sample, and mode 1 cannot fire on the first WAIT cycle after PRE_TRIG=0 arm.
//   trig_mask_i == 0: mode 0 always fires, mode 1 never fires.
//  On trigger: trig_ptr = wr_ptr.
//   Readout start = trig_ptr - PRE_TRIG, modulo DEPTH.
//   Total captured = DEPTH, so the trigger sample is read index PRE_TRIG.
//  Readout: one sample per accepted rd_req_i, back-to-back allowed (1 per clk).
//   RAM read latency is 1: data and rd_valid_o appear the next clk.
//   rd_last_o is asserted with read index DEPTH-1.
//   After the last read, rd_req_i is ignored until re-armed.
//   rd_req_i outside DONE: ignored, no strobe.
//  Re-arm in DONE mid-readout: read counter is cleared.
//   Any in-flight rd_valid_o still fires next cycle with the old data.
//  abort_i or reset mid-capture: no partial-capture state survives.
// STRUCTURE
//  Package probe_capture_pkg:
//   - state encoding: IDLE, PRE, WAIT, POST, DONE
//   - TRIG_MATCH = 1'b0, TRIG_CHANGE = 1'b1
//   - function clog2
//  Sub-module sdp_ram:
//   - simple dual-port RAM, one write port and one registered read port
//   - parameters W, DEPTH; no reset on the storage array (maps to BSRAM)
//  All logic in clk domain; no CDC inside this block.
// TESTING (PROBE_W=24, DEPTH=256, PRE_TRIG=32 unless noted)
//  1. probe=counter from 0, arm at t0, mode0 mask=FFFFFF val=000100 -> 256 reads
//     return 0x0E0..0x1DF; index 32 = 0x100; rd_last with 0x1DF.
//  2. Trigger value present during PRE only (val=000005, arm at probe=0)
//     -> not captured; still WAIT; armed_o=1, triggered_o=0.
//  3. Mode1 mask=000001, probe bit0 toggles once at cycle 100 after arm
//     -> read index 32 holds the toggled value; index 31 holds the old value.
//  4. Ptr wrap: arm, wait 1000 cycles, then trigger
//     -> readout start = (trig_ptr-32) mod 256; data contiguous across the wrap.
//  5. abort_i together with arm_i, and abort in POST -> IDLE next clk, all status 0;
//     rst_n low mid-POST -> same; rd_req_i in IDLE -> no rd_valid_o.
//  6. PRE_TRIG=0, mode0 trigger on the first WAIT sample -> index 0 = trigger sample;
//     back-to-back rd_req for 256 clks -> 256 strobes, then none.

Source files
------------

// File: rtl/probe_capture_pkg.sv
// Shared types and helpers for the probe_capture logic-analyser core.
package probe_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic TRIG_MATCH  = 1'b0;
    localparam logic TRIG_CHANGE = 1'b1;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'(1) << res) < 64'(value)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/probe_capture_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module sdp_ram
    import probe_capture_pkg::*;
#(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [W-1:0]              wdata_i,
    input  logic                      re_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [W-1:0]              rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/probe_capture.sv
// Logic-analyser core: circular capture with masked trigger and oldest-first pull readout.
module probe_capture
    import probe_capture_pkg::*;
#(
    parameter int unsigned PROBE_W  = 24,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned PRE_TRIG = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trig_mode_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [PROBE_W-1:0] trig_val_i,
    input  logic               rd_req_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic               rd_last_o,
    output logic               armed_o,
    output logic               triggered_o,
    output logic               done_o
);

    localparam int unsigned AW     = clog2(DEPTH);
    localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW-1:0]      rd_start_q, rd_start_d;
    logic [AW-1:0]      rd_idx_q, rd_idx_d;
    logic               rd_done_q, rd_done_d;
    logic [PROBE_W-1:0] prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               rd_valid_q, rd_last_q;
    logic               armed_q, triggered_q, done_q;

    logic               capturing;
    logic               wr_en;
    logic               rd_en;
    logic               start_cap;
    logic               trig_match;
    logic               trig_change;
    logic               trig_hit;
    logic [AW-1:0]      rd_addr;

    // Mode 1 needs a valid previous sample, so it cannot fire on the first write after arm.
    always_comb begin
        trig_match  = ((probe_i ^ trig_val_i) & trig_mask_i) == '0;
        trig_change = prev_vld_q && (((probe_i ^ prev_q) & trig_mask_i) != '0);
        trig_hit    = (trig_mode_i == TRIG_CHANGE) ? trig_change : trig_match;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        rd_start_d = rd_start_q;
        rd_idx_d   = rd_idx_q;
        rd_done_d  = rd_done_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        start_cap  = 1'b0;

        capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
        if (capturing) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            prev_d     = probe_i;
            prev_vld_d = 1'b1;
        end

        rd_en = (state_q == ST_DONE) && !rd_done_q && rd_req_i && !arm_i && !abort_i;
        if (rd_en) begin
            rd_idx_d = rd_idx_q + AW'(1);
            if (rd_idx_q == AW'(DEPTH - 1)) begin
                rd_done_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm_i) start_cap = 1'b1;
            end
            ST_PRE: begin
                if (pre_cnt_q == AW'(PRE_TRIG - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    pre_cnt_d = pre_cnt_q + AW'(1);
                end
            end
            ST_WAIT: begin
                if (trig_hit) begin
                    rd_start_d = wr_ptr_q - AW'(PRE_TRIG);
                    state_d    = (POST_N == 0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (post_cnt_q == AW'(POST_N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    post_cnt_d = post_cnt_q + AW'(1);
                end
            end
            ST_DONE: begin
                if (arm_i) start_cap = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_cap) begin
            state_d    = (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            rd_idx_d   = '0;
            rd_done_d  = 1'b0;
            prev_vld_d = 1'b0;
        end

        // Abort overrides everything, including a same-cycle arm.
        if (abort_i) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            rd_start_d = '0;
            rd_idx_d   = '0;
            rd_done_d  = 1'b0;
            prev_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_start_q  <= '0;
            rd_idx_q    <= '0;
            rd_done_q   <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_start_q  <= rd_start_d;
            rd_idx_q    <= rd_idx_d;
            rd_done_q   <= rd_done_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            rd_valid_q  <= rd_en;
            rd_last_q   <= rd_en && (rd_idx_q == AW'(DEPTH - 1));
            armed_q     <= (state_d == ST_PRE) || (state_d == ST_WAIT);
            triggered_q <= (state_d == ST_POST) || (state_d == ST_DONE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign rd_addr = rd_start_q + rd_idx_q;

    sdp_ram #(
        .W     (PROBE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (probe_i),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign armed_o     = armed_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_probe_capture.sv
// Directed bench for probe_capture: PRE_TRIG=32 instance (a) and PRE_TRIG=0 instance (b).
module tb_probe_capture;

    localparam int unsigned W     = 24;
    localparam int unsigned DEPTH = 256;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] probe;
    logic         trig_mode;
    logic [W-1:0] trig_mask;
    logic [W-1:0] trig_val;
    logic         arm_a, abort_a, rd_req_a;
    logic         arm_b, abort_b, rd_req_b;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, a_last, a_armed, a_trig, a_done;
    logic         b_valid, b_last, b_armed, b_trig, b_done;

    int           checks = 0;
    int           errors = 0;
    int           cnt    = 0;
    int           gen_mode  = 0;
    int           toggle_at = 0;
    logic [W-1:0] rbuf [DEPTH];
    int           nstrobe, nlast, last_idx;

    probe_capture #(.PROBE_W(W), .DEPTH(DEPTH), .PRE_TRIG(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .probe_i(probe), .arm_i(arm_a), .abort_i(abort_a),
        .trig_mode_i(trig_mode), .trig_mask_i(trig_mask), .trig_val_i(trig_val),
        .rd_req_i(rd_req_a), .rd_data_o(a_data), .rd_valid_o(a_valid), .rd_last_o(a_last),
        .armed_o(a_armed), .triggered_o(a_trig), .done_o(a_done)
    );

    probe_capture #(.PROBE_W(W), .DEPTH(DEPTH), .PRE_TRIG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .probe_i(probe), .arm_i(arm_b), .abort_i(abort_b),
        .trig_mode_i(trig_mode), .trig_mask_i(trig_mask), .trig_val_i(trig_val),
        .rd_req_i(rd_req_b), .rd_data_o(b_data), .rd_valid_o(b_valid), .rd_last_o(b_last),
        .armed_o(b_armed), .triggered_o(b_trig), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] probe_val(input int c);
        if (gen_mode == 1) return W'((c << 1) | ((c >= toggle_at) ? 1 : 0));
        return W'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n);
        repeat (n) begin
            probe = probe_val(cnt);
            step();
            cnt++;
        end
    endtask

    task automatic arm_dut(input bit sel);
        probe = probe_val(cnt);
        if (sel) arm_b = 1'b1; else arm_a = 1'b1;
        step();
        cnt++;
        arm_a = 1'b0;
        arm_b = 1'b0;
    endtask

    task automatic abort_a_pulse();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, input string tag);
        int n;
        n = 0;
        while (!(sel ? b_done : a_done) && n < budget) begin
            drive(1);
            n++;
        end
        check(tag, 64'(sel ? b_done : a_done), 64'd1);
    endtask

    task automatic readout(input bit sel, input int extra);
        nstrobe  = 0;
        nlast    = 0;
        last_idx = -1;
        for (int i = 0; i < int'(DEPTH) + extra + 2; i++) begin
            if (sel) rd_req_b = (i < int'(DEPTH) + extra);
            else     rd_req_a = (i < int'(DEPTH) + extra);
            step();
            if (sel ? b_valid : a_valid) begin
                if (nstrobe < int'(DEPTH)) rbuf[nstrobe] = sel ? b_data : a_data;
                if (sel ? b_last : a_last) begin
                    nlast++;
                    last_idx = nstrobe;
                end
                nstrobe++;
            end
        end
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
    endtask

    function automatic int contig_errs(input logic [W-1:0] base);
        int e;
        e = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rbuf[i] !== W'(base + W'(i))) e++;
        end
        return e;
    endfunction

    task automatic check_status(input string tag, input bit armed, input bit trig, input bit done);
        check({tag, ".armed"}, 64'(a_armed), 64'(armed));
        check({tag, ".triggered"}, 64'(a_trig), 64'(trig));
        check({tag, ".done"}, 64'(a_done), 64'(done));
    endtask

    initial begin
        int n_strb;
        rst_n = 1'b0; probe = '0; trig_mode = 1'b0; trig_mask = '0; trig_val = '0;
        arm_a = 1'b0; abort_a = 1'b0; rd_req_a = 1'b0;
        arm_b = 1'b0; abort_b = 1'b0; rd_req_b = 1'b0;
        step();
        step();
        check_status("reset", 1'b0, 1'b0, 1'b0);
        check("reset.rd_valid", 64'(a_valid), 64'd0);
        check("reset.rd_last", 64'(a_last), 64'd0);
        check("reset.rd_data", 64'(a_data), 64'd0);
        check("reset.b_done", 64'(b_done), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: counter probe, match on 0x000100
        gen_mode = 0; cnt = 0;
        trig_mode = 1'b0; trig_mask = 24'hFFFFFF; trig_val = 24'h000100;
        arm_dut(1'b0);
        check_status("t1.armed", 1'b1, 1'b0, 1'b0);
        wait_done(1'b0, 2000, "t1.done");
        check_status("t1.end", 1'b0, 1'b1, 1'b1);
        readout(1'b0, 4);
        check("t1.strobes", 64'(nstrobe), 64'd256);
        check("t1.nlast", 64'(nlast), 64'd1);
        check("t1.last_idx", 64'(last_idx), 64'd255);
        check("t1.idx0", 64'(rbuf[0]), 64'h0E0);
        check("t1.idx32", 64'(rbuf[32]), 64'h100);
        check("t1.idx255", 64'(rbuf[255]), 64'h1DF);
        check("t1.contig", 64'(contig_errs(24'h0E0)), 64'd0);

        // 2: trigger value only seen during PRE is lost
        cnt = 0; trig_val = 24'h000005;
        arm_dut(1'b0);
        drive(60);
        check_status("t2.wait", 1'b1, 1'b0, 1'b0);
        abort_a_pulse();
        check_status("t2.abort", 1'b0, 1'b0, 1'b0);

        // 3: mode 1 on bit0 toggling at sample 100
        gen_mode = 1; toggle_at = 100; cnt = 0;
        trig_mode = 1'b1; trig_mask = 24'h000001;
        arm_dut(1'b0);
        wait_done(1'b0, 2000, "t3.done");
        readout(1'b0, 0);
        check("t3.strobes", 64'(nstrobe), 64'd256);
        check("t3.idx31", 64'(rbuf[31]), 64'(probe_val(99)));
        check("t3.idx32", 64'(rbuf[32]), 64'(probe_val(100)));
        check("t3.idx0", 64'(rbuf[0]), 64'(probe_val(68)));

        // 4: trigger after 1000 samples, readout wraps across the buffer end
        gen_mode = 0; cnt = 0;
        trig_mode = 1'b0; trig_mask = 24'hFFFFFF; trig_val = 24'h0003E8;
        arm_dut(1'b0);
        drive(990);
        check_status("t4.wait", 1'b1, 1'b0, 1'b0);
        wait_done(1'b0, 2000, "t4.done");
        readout(1'b0, 0);
        check("t4.idx0", 64'(rbuf[0]), 64'h3C8);
        check("t4.idx32", 64'(rbuf[32]), 64'h3E8);
        check("t4.idx255", 64'(rbuf[255]), 64'h4C7);
        check("t4.contig", 64'(contig_errs(24'h3C8)), 64'd0);

        // 5a: abort wins over a simultaneous arm
        arm_a = 1'b1; abort_a = 1'b1;
        step();
        arm_a = 1'b0; abort_a = 1'b0;
        check_status("t5.abort_arm", 1'b0, 1'b0, 1'b0);
        step();
        check_status("t5.abort_arm2", 1'b0, 1'b0, 1'b0);
        // 5b: rd_req in IDLE produces no strobe
        n_strb = 0;
        for (int i = 0; i < 6; i++) begin
            rd_req_a = (i < 4);
            step();
            if (a_valid) n_strb++;
        end
        rd_req_a = 1'b0;
        check("t5.idle_rd", 64'(n_strb), 64'd0);
        // 5c: abort in POST
        cnt = 0; trig_val = 24'h000040;
        arm_dut(1'b0);
        drive(70);
        check_status("t5.post", 1'b0, 1'b1, 1'b0);
        abort_a_pulse();
        check_status("t5.post_abort", 1'b0, 1'b0, 1'b0);
        // 5d: asynchronous reset in POST
        cnt = 0;
        arm_dut(1'b0);
        drive(70);
        check_status("t5.post2", 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_status("t5.rst", 1'b0, 1'b0, 1'b0);
        check("t5.rst.rd_valid", 64'(a_valid), 64'd0);
        step();
        rst_n = 1'b1;
        drive(3);
        check_status("t5.rst_after", 1'b0, 1'b0, 1'b0);

        // 6: PRE_TRIG=0, trigger on the first WAIT sample
        gen_mode = 0; cnt = 0;
        trig_mode = 1'b0; trig_mask = 24'hFFFFFF; trig_val = 24'h000001;
        arm_dut(1'b1);
        check("t6.armed", 64'(b_armed), 64'd1);
        wait_done(1'b1, 2000, "t6.done");
        check("t6.triggered", 64'(b_trig), 64'd1);
        readout(1'b1, 8);
        check("t6.strobes", 64'(nstrobe), 64'd256);
        check("t6.last_idx", 64'(last_idx), 64'd255);
        check("t6.idx0", 64'(rbuf[0]), 64'h001);
        check("t6.contig", 64'(contig_errs(24'h001)), 64'd0);

        // 6b: mode 1 cannot fire on the first WAIT sample; re-arm from DONE
        cnt = 500; trig_mode = 1'b1; trig_mask = 24'hFFFFFF;
        arm_dut(1'b1);
        wait_done(1'b1, 2000, "t6b.done");
        readout(1'b1, 0);
        check("t6b.idx0", 64'(rbuf[0]), 64'h1F6);
        check("t6b.idx255", 64'(rbuf[255]), 64'h2F5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
